firmach_decim: RTL and testbench

FIRMACH_DECIM -- requirements
Module: firmach_decim

---
 rtl/firmach_decim.sv | 210 +++++++++++++++++++++
 tb/tb_firmach_decim.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/firmach_decim.sv
// firmach_decim: decimating FIR filter with an external registered coefficient ROM.
// Each accepted sample goes into a TAPS-deep circular buffer. After every DECIM
// accepted samples, the filter runs one multiply-accumulate per tap, drains its
// pipeline, then presents one saturated 24-bit result and holds it until the
// downstream side accepts it. Input is stalled for the whole computation.
//
// Parameters:
//   TAPS   filter length and ROM depth (power of two, 2..256)
//   DECIM  input samples per output (1..256)
//   ACC_W  accumulator width
// Ports:
//   clock      sole clock, rising edge
//   reset_n    synchronous active-low reset
//   in_valid   upstream sample valid
//   in_ready   block accepts a sample (transfer on in_valid & in_ready)
//   in_data    signed 24-bit sample
//   coef_addr  coefficient ROM address (0 outside the MAC phase)
//   coef_q     signed Q1.17 coefficient, one clock after coef_addr
//   out_valid  output sample valid
//   out_ready  downstream accepts (transfer on out_valid & out_ready)
//   out_data   signed 24-bit filtered, decimated sample
// Configuration:
//   FIRMACH_ROUND_EN  when defined, round half up before the >>>17 scaling;
//                     otherwise truncate toward minus infinity.
module firmach_decim #(
  parameter int unsigned TAPS  = 256,
  parameter int unsigned DECIM = 8,
  parameter int unsigned ACC_W = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic [7:0]  coef_addr,
  input  logic [17:0] coef_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data
);

  localparam int unsigned DW    = 24;
  localparam int unsigned CWID  = 18;
  localparam int unsigned PRW   = DW + CWID;
  localparam int unsigned AW    = 8;
  localparam int unsigned PW    = $clog2(TAPS);
  localparam int unsigned CNTW  = 9;
  localparam int unsigned SHIFT = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           n_q, n_d;
  logic [PW-1:0]           rd_idx;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    flush_q, flush_d;
  logic signed [DW-1:0]    samp_q, samp_d;
  logic signed [PRW-1:0]   prod_q, prod_d;
  logic                    v1_q, v1_d;
  logic                    v2_q, v2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [ACC_W:0]   acc_rnd, acc_sh;
  logic [DW-1:0]           sat_c;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic                    wr_en;
  logic [DW-1:0]           mem_q [TAPS];

  // MAC datapath: buffer read -> (aligned with coef_q) product -> accumulate -> scale/saturate
  always_comb begin
    rd_idx  = n_q - PW'(addr_q);
    samp_d  = $signed(mem_q[rd_idx]);
    prod_d  = PRW'(samp_q) * PRW'($signed(coef_q));
    acc_sum = v2_q ? (acc_q + ACC_W'(prod_q)) : acc_q;
    acc_rnd = (ACC_W+1)'(acc_sum);
`ifdef FIRMACH_ROUND_EN
    acc_rnd = acc_rnd + (ACC_W+1)'(1 << (SHIFT-1));
`endif
    acc_sh  = acc_rnd >>> SHIFT;
    // In range when every bit from the sign down to bit 23 agrees.
    if ((&acc_sh[ACC_W:DW-1]) || (~|acc_sh[ACC_W:DW-1])) begin
      sat_c = acc_sh[DW-1:0];
    end else if (acc_sh[ACC_W]) begin
      sat_c = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_c = {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Next-state and control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    n_d         = n_q;
    addr_d      = addr_q;
    flush_d     = flush_q;
    acc_d       = acc_sum;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wr_en       = 1'b0;
    v1_d        = (state_q == S_RUN);
    v2_d        = v1_q;

    unique case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (cnt_q == CNTW'(DECIM - 1)) begin
            cnt_d      = '0;
            n_d        = wr_ptr_q;
            addr_d     = '0;
            acc_d      = '0;
            in_ready_d = 1'b0;
            state_d    = S_RUN;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      S_RUN: begin
        if (addr_q == AW'(TAPS - 1)) begin
          addr_d  = '0;
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_FLUSH: begin
        // Second flush cycle adds the last product; capture the scaled result now.
        if (flush_q) begin
          flush_d     = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = sat_c;
          state_d     = S_OUT;
        end else begin
          flush_d = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      flush_q     <= 1'b0;
      samp_q      <= '0;
      prod_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      flush_q     <= flush_d;
      samp_q      <= samp_d;
      prod_q      <= prod_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Sample buffer survives reset; only the pointer is cleared.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign coef_addr = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_firmach_decim.sv
// Testbench for firmach_decim (TAPS=16, DECIM=8) with a registered ROM model
// and a scoreboard of expected outputs and output cycles.
module tb_firmach_decim;

  localparam int TAPS  = 16;
  localparam int DECIM = 8;
  localparam int LAT   = TAPS + 3;

  typedef struct {
    bit     chk;
    longint val;
    int     cyc;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [7:0]  coef_addr;
  logic [17:0] coef_q;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;

  logic [17:0] coef_mem [256];
  longint      hist [TAPS];
  exp_t        sb [$];
  longint      outs [$];
  int          widx, nacc, dcnt;
  int          n_cmp, n_err;
  int          cyc;
  int          nout;
  longint      last_out;
  logic        rst_s;

  firmach_decim #(
    .TAPS (TAPS),
    .DECIM(DECIM),
    .ACC_W(50)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .coef_addr(coef_addr),
    .coef_q   (coef_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered coefficient ROM, cycle counter, reset as seen by the last edge
  always @(posedge clock) begin
    coef_q <= coef_mem[coef_addr];
    cyc    <= cyc + 1;
    rst_s  <= reset_n;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model_out(input int n);
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      s += longint'($signed(coef_mem[k])) * hist[(n - k + TAPS) % TAPS];
    end
`ifdef FIRMACH_ROUND_EN
    s += 65536;
`endif
    s = s >>> 17;
    if (s > 8388607) s = 8388607;
    else if (s < -8388608) s = -8388608;
    return s;
  endfunction

  task automatic monitor();
    bit          prev_rst;
    bit          prev_ov;
    logic [23:0] held;
    exp_t        e;
    prev_rst = 1'b1;
    prev_ov  = 1'b0;
    held     = '0;
    forever begin
      @(negedge clock);
      if (rst_s === 1'b0) begin
        check("rst_out_valid", out_valid, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_in_ready", in_ready, 0);
        sb.delete();
        widx = 0; nacc = 0; dcnt = 0;
        prev_ov = 1'b0;
      end else begin
        if (!prev_rst) check("rel_in_ready", in_ready, 1);
        if (out_valid && !prev_ov) begin
          check("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) check("latency", cyc, sb[0].cyc);
          held = out_data;
        end else if (out_valid) begin
          check("hold_data", out_data, held);
          check("hold_in_ready", in_ready, 0);
        end
        if (out_valid && out_ready) begin
          nout++;
          last_out = longint'($signed(out_data));
          outs.push_back(last_out);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) check("out_data", last_out, e.val);
          end
        end
        if (reset_n && in_valid && in_ready) begin
          int n;
          n = widx;
          hist[widx] = longint'($signed(in_data));
          widx = (widx + 1) % TAPS;
          nacc++;
          dcnt++;
          if (dcnt == DECIM) begin
            dcnt = 0;
            e.chk = (nacc >= TAPS);
            e.val = model_out(n);
            e.cyc = cyc + LAT;
            sb.push_back(e);
          end
        end
        prev_ov = out_valid && !out_ready;
      end
      prev_rst = (rst_s === 1'b1);
    end
  endtask

  task automatic send(input logic [23:0] d);
    bit ok;
    int b;
    ok = 1'b0;
    b  = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && b < 500) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      b++;
    end
    if (!ok) check("send_timeout", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((sb.size() != 0 || out_valid) && b < 3000) begin
      @(posedge clock);
      #1;
      b++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic rand_coefs();
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 18'($urandom_range(8191)) - 18'd4096;
  endtask

  initial begin
    int n0;
    n_cmp = 0; n_err = 0; cyc = 0; nout = 0; last_out = 0;
    widx = 0; nacc = 0; dcnt = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < 256; k++) coef_mem[k] = 18'(1000 + k);
    fork
      monitor();
    join_none
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b1;

    // Impulse of 1.0 at sample 18 reads back the coefficients
    for (int i = 0; i < 48; i++) send((i == 18) ? 24'h020000 : 24'h000000);
    drain();
    check("imp_c5", outs[2], 1005);
    check("imp_c13", outs[3], 1013);
    check("imp_zero", outs[4], 0);

    // Continuous stream, random data and coefficients
    rand_coefs();
    n0 = nout;
    for (int i = 0; i < 800; i++) send(24'($urandom));
    drain();
    check("stream_count", nout - n0, 100);

    // Saturation both ways
    for (int k = 0; k < TAPS; k++) coef_mem[k] = 18'h1FFFF;
    for (int i = 0; i < 16; i++) send(24'h7FFFFF);
    drain();
    check("sat_pos", last_out, 8388607);
    for (int i = 0; i < 16; i++) send(24'h800000);
    drain();
    check("sat_neg", last_out, -8388608);

    // Half-LSB result: rounds up only when rounding is enabled
    for (int k = 0; k < TAPS; k++) coef_mem[k] = '0;
    coef_mem[0] = 18'd1;
    for (int i = 0; i < 7; i++) send(24'h000000);
    send(24'h010000);
    drain();
`ifdef FIRMACH_ROUND_EN
    check("round", last_out, 1);
`else
    check("round", last_out, 0);
`endif

    // Backpressure: output held 50 cycles while upstream offers a sample
    rand_coefs();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(24'($urandom));
    for (int i = 0; i < 300 && !out_valid; i++) begin
      @(posedge clock);
      #1;
    end
    check("bp_out_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 24'h123456;
    repeat (50) begin
      @(posedge clock);
      #1;
    end
    check("bp_still_valid", out_valid, 1);
    n0 = nout;
    out_ready = 1'b1;
    send(24'h123456);
    check("bp_one_xfer", nout - n0, 1);
    for (int i = 0; i < 7; i++) send(24'($urandom));
    drain();
    check("bp_next", nout - n0, 2);

    // Reset in the middle of a computation discards it
    for (int i = 0; i < 8; i++) send(24'($urandom));
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b1;
    n0 = nout;
    repeat (LAT + 10) @(posedge clock);
    #1;
    check("no_stale", nout - n0, 0);
    for (int i = 0; i < 24; i++) send(24'($urandom));
    drain();
    check("resume_count", nout - n0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
